// File: rtl/mm_burst_arbiter_if.sv
// Bundle of the two requester ports and the AXI4 read channels around mm_burst_arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface mm_burst_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [3:0]            req0_len;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_rdata;
  logic                  req0_rvalid;
  logic                  req0_rlast;
  logic                  req0_err;

  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [3:0]            req1_len;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_rdata;
  logic                  req1_rvalid;
  logic                  req1_rlast;
  logic                  req1_err;

  logic                  m_arvalid;
  logic                  m_arready;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic                  m_arid;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic                  m_rvalid;
  logic                  m_rready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rlast;

  logic                  proto_err;

  modport master (
    input  req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len,
    output req0_ready, req0_rdata, req0_rvalid, req0_rlast, req0_err,
    output req1_ready, req1_rdata, req1_rvalid, req1_rlast, req1_err,
    output m_arvalid, m_araddr, m_arlen, m_arid, m_arsize, m_arburst,
    input  m_arready,
    input  m_rvalid, m_rdata, m_rresp, m_rlast,
    output m_rready, proto_err
  );

  modport slave (
    output req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len,
    input  req0_ready, req0_rdata, req0_rvalid, req0_rlast, req0_err,
    input  req1_ready, req1_rdata, req1_rvalid, req1_rlast, req1_err,
    input  m_arvalid, m_araddr, m_arlen, m_arid, m_arsize, m_arburst,
    output m_arready,
    output m_rvalid, m_rdata, m_rresp, m_rlast,
    input  m_rready, proto_err
  );
endinterface

// File: rtl/mm_burst_arbiter.sv
// Two-requester round-robin arbiter issuing one AXI4 INCR read burst at a time.
// Rejects misaligned or 4 KB-crossing requests and flags rlast misplacement.
module mm_burst_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                 ACLK,
  input logic                 ARESETN,
  mm_burst_arbiter_if.master  bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            len_q, len_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  proto_q, proto_d;
  logic                  berr_q, berr_d;

  logic                  grant;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [3:0]            sel_len;
  logic [12:0]           end_off;
  logic                  reject;
  logic                  in_data;
  logic [1:0]            ready_v, err_v;
  logic                  arvalid, rready;

  // With both valid, alternate; with one valid, it wins outright.
  assign grant    = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  assign sel_addr = grant ? bus.req1_addr : bus.req0_addr;
  assign sel_len  = grant ? bus.req1_len  : bus.req0_len;
  assign end_off  = {1'b0, sel_addr[11:0]} + {7'd0, sel_len, 2'b00} + 13'd4;
  assign reject   = (sel_addr[1:0] != 2'b00) || (end_off > 13'd4096);
  assign in_data  = (state_q == DATA);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    proto_d      = proto_q;
    berr_d       = berr_q;
    ready_v      = 2'b00;
    err_v        = 2'b00;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          last_grant_d   = grant;
          ready_v[grant] = 1'b1;
          if (reject) begin
            err_v[grant] = 1'b1;
          end else begin
            owner_d = grant;
            addr_d  = sel_addr;
            len_d   = sel_len;
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        arvalid = 1'b1;
        if (bus.m_arready) begin
          cnt_d   = 5'd0;
          berr_d  = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        rready = 1'b1;
        if (bus.m_rvalid) begin
          cnt_d = cnt_q + 5'd1;
          if (bus.m_rresp != 2'b00) berr_d = 1'b1;
          // rlast must coincide exactly with the beat whose index equals len.
          if (bus.m_rlast != (cnt_q == {1'b0, len_q})) proto_d = 1'b1;
          if (bus.m_rlast) begin
            err_v[owner_q] = berr_q || (bus.m_rresp != 2'b00);
            state_d        = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!ARESETN) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      proto_q      <= 1'b0;
      berr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      proto_q      <= proto_d;
      berr_q       <= berr_d;
    end
  end

  assign bus.req0_ready  = ready_v[0];
  assign bus.req1_ready  = ready_v[1];
  assign bus.req0_err    = err_v[0];
  assign bus.req1_err    = err_v[1];
  assign bus.req0_rvalid = in_data && bus.m_rvalid && !owner_q;
  assign bus.req1_rvalid = in_data && bus.m_rvalid &&  owner_q;
  assign bus.req0_rlast  = in_data && bus.m_rlast  && !owner_q;
  assign bus.req1_rlast  = in_data && bus.m_rlast  &&  owner_q;
  assign bus.req0_rdata  = in_data ? bus.m_rdata : '0;
  assign bus.req1_rdata  = in_data ? bus.m_rdata : '0;

  assign bus.m_arvalid   = arvalid;
  assign bus.m_araddr    = addr_q;
  assign bus.m_arlen     = {4'b0000, len_q};
  assign bus.m_arid      = owner_q;
  assign bus.m_arsize    = 3'b010;
  assign bus.m_arburst   = 2'b01;
  assign bus.m_rready    = rready;
  assign bus.proto_err   = proto_q;
endmodule

// File: tb/tb_mm_burst_arbiter.sv
// Directed bench for mm_burst_arbiter: AR and R-beat expectations go through scoreboard queues
// filled as stimulus is driven and drained as the arbiter responds.
module tb_mm_burst_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic tb_ACLK = 1'b0;
  logic ARESETN;
  always #5 tb_ACLK = ~tb_ACLK;

  mm_burst_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mm_burst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK    (tb_ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  typedef struct {
    int          who;
    logic [AW-1:0] addr;
    logic [3:0]  len;
  } ar_t;

  typedef struct {
    int          who;
    logic [DW-1:0] data;
    logic        last;
    logic        err;
  } beat_t;

  ar_t   ar_q[$];
  beat_t beat_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_len = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_len = '0;
    bus.m_arready  = 1'b0;
    bus.m_rvalid   = 1'b0; bus.m_rdata = '0; bus.m_rresp = 2'b00; bus.m_rlast = 1'b0;
  endtask

  // One IDLE cycle: present a request, expect an immediate ready (and err when rejected).
  task automatic request(input int who, input logic [AW-1:0] addr, input logic [3:0] len, input bit rej);
    @(negedge tb_ACLK);
    if (who == 0) begin bus.req0_valid = 1'b1; bus.req0_addr = addr; bus.req0_len = len; end
    else          begin bus.req1_valid = 1'b1; bus.req1_addr = addr; bus.req1_len = len; end
    #1;
    check($sformatf("ready%0d", who), who ? bus.req1_ready : bus.req0_ready, 1);
    check("ready_other", who ? bus.req0_ready : bus.req1_ready, 0);
    check($sformatf("grant_err%0d", who), who ? bus.req1_err : bus.req0_err, rej);
    check("arvalid_in_idle", bus.m_arvalid, 0);
    if (!rej) ar_q.push_back('{who, addr, len});
    @(posedge tb_ACLK); #1;
    if (who == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic addr_phase(input int stall);
    ar_t exp;
    @(negedge tb_ACLK); #1;
    exp = ar_q.pop_front();
    check("ready_pulse_width", bus.req0_ready | bus.req1_ready, 0);
    for (int s = 0; s < stall; s++) begin
      check("arvalid_stall", bus.m_arvalid, 1);
      check("araddr_stall", bus.m_araddr, exp.addr);
      @(negedge tb_ACLK); #1;
    end
    bus.m_arready = 1'b1;
    #1;
    check("arvalid", bus.m_arvalid, 1);
    check("araddr", bus.m_araddr, exp.addr);
    check("arlen", bus.m_arlen, {4'b0000, exp.len});
    check("arid", bus.m_arid, exp.who);
    check("arsize", bus.m_arsize, 3'b010);
    check("arburst", bus.m_arburst, 2'b01);
    check("rready_in_addr", bus.m_rready, 0);
    @(posedge tb_ACLK); #1;
    bus.m_arready = 1'b0;
  endtask

  // Slave returns nbeats; err_beat gets SLVERR, rlast_beat carries rlast (-1 = none).
  task automatic data_phase(input int who, input int nbeats, input int err_beat, input int rlast_beat);
    bit    saw_err;
    beat_t e;
    saw_err = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      @(negedge tb_ACLK);
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = $urandom;
      bus.m_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      bus.m_rlast  = (i == rlast_beat);
      saw_err      = saw_err | (i == err_beat);
      beat_q.push_back('{who, bus.m_rdata, (i == rlast_beat), (i == rlast_beat) && saw_err});
      #1;
      e = beat_q.pop_front();
      check("rready", bus.m_rready, 1);
      check($sformatf("rvalid0_beat%0d", i), bus.req0_rvalid, e.who == 0);
      check($sformatf("rvalid1_beat%0d", i), bus.req1_rvalid, e.who == 1);
      check($sformatf("rdata_beat%0d", i), e.who ? bus.req1_rdata : bus.req0_rdata, e.data);
      check($sformatf("rlast0_beat%0d", i), bus.req0_rlast, e.last && e.who == 0);
      check($sformatf("rlast1_beat%0d", i), bus.req1_rlast, e.last && e.who == 1);
      check($sformatf("err0_beat%0d", i), bus.req0_err, e.err && e.who == 0);
      check($sformatf("err1_beat%0d", i), bus.req1_err, e.err && e.who == 1);
      @(posedge tb_ACLK); #1;
      bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.m_rresp = 2'b00;
    end
  endtask

  initial begin
    drive_idle();
    ARESETN = 1'b0;
    bus.m_rvalid = 1'b1; bus.m_rlast = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge tb_ACLK);
    @(negedge tb_ACLK); #1;
    check("rst_arvalid", bus.m_arvalid, 0);
    check("rst_araddr", bus.m_araddr, 0);
    check("rst_arlen", bus.m_arlen, 0);
    check("rst_arid", bus.m_arid, 0);
    check("rst_arsize", bus.m_arsize, 3'b010);
    check("rst_arburst", bus.m_arburst, 2'b01);
    check("rst_rready", bus.m_rready, 0);
    check("rst_proto_err", bus.proto_err, 0);
    check("rst_rvalid0", bus.req0_rvalid, 0);
    check("rst_rdata0", bus.req0_rdata, 0);
    check("rst_rlast1", bus.req1_rlast, 0);
    check("rst_ready", bus.req0_ready | bus.req1_ready, 0);
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.m_rdata = '0;
    ARESETN = 1'b1;

    // Both requesters contend straight out of reset: req0 first, req1 in the next IDLE cycle.
    @(negedge tb_ACLK);
    bus.req0_valid = 1'b1; bus.req0_addr = 32'h200; bus.req0_len = 4'd3;
    bus.req1_valid = 1'b1; bus.req1_addr = 32'h300; bus.req1_len = 4'd3;
    #1;
    check("contend_ready0", bus.req0_ready, 1);
    check("contend_ready1", bus.req1_ready, 0);
    check("contend_err", bus.req0_err | bus.req1_err, 0);
    ar_q.push_back('{0, 32'h200, 4'd3});
    @(posedge tb_ACLK); #1;
    bus.req0_valid = 1'b0;
    addr_phase(0);
    data_phase(0, 4, -1, 3);
    request(1, 32'h300, 4'd3, 1'b0);
    addr_phase(0);
    data_phase(1, 4, -1, 3);

    // Full 16-beat burst.
    request(0, 32'h100, 4'd15, 1'b0);
    addr_phase(0);
    data_phase(0, 16, -1, 15);

    // Rejections: 4 KB crossing and misalignment; exact-fit to the boundary is accepted.
    request(1, 32'hFF8, 4'd3, 1'b1);
    @(negedge tb_ACLK); #1;
    check("reject_no_arvalid", bus.m_arvalid, 0);
    check("reject_ready_gone", bus.req1_ready, 0);
    request(0, 32'h102, 4'd0, 1'b1);
    @(negedge tb_ACLK); #1;
    check("misalign_no_arvalid", bus.m_arvalid, 0);
    request(1, 32'hFF0, 4'd3, 1'b0);
    addr_phase(0);
    data_phase(1, 4, -1, 3);

    // AR back-pressure for 5 cycles, SLVERR on beat 3 reported at rlast.
    request(0, 32'h400, 4'd3, 1'b0);
    addr_phase(5);
    data_phase(0, 4, 2, 3);
    @(negedge tb_ACLK); #1;
    check("slverr_no_proto", bus.proto_err, 0);

    // Early rlast: proto_err set, FSM back in IDLE, flag stays sticky across a clean burst.
    request(1, 32'h800, 4'd7, 1'b0);
    addr_phase(0);
    data_phase(1, 5, -1, 4);
    @(negedge tb_ACLK); #1;
    check("early_rlast_proto", bus.proto_err, 1);
    check("early_rlast_idle_rready", bus.m_rready, 0);
    check("early_rlast_idle_arvalid", bus.m_arvalid, 0);
    request(0, 32'h900, 4'd1, 1'b0);
    addr_phase(0);
    data_phase(0, 2, -1, 1);
    @(negedge tb_ACLK); #1;
    check("proto_sticky", bus.proto_err, 1);

    // Reset in the middle of a burst abandons it; stray beats are ignored.
    request(1, 32'hA00, 4'd7, 1'b0);
    addr_phase(0);
    data_phase(1, 2, -1, -1);
    @(negedge tb_ACLK);
    ARESETN = 1'b0;
    @(posedge tb_ACLK); #1;
    ARESETN = 1'b1;
    @(negedge tb_ACLK);
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1234_5678;
    #1;
    check("midrst_proto_cleared", bus.proto_err, 0);
    check("midrst_rready", bus.m_rready, 0);
    check("midrst_rvalid0", bus.req0_rvalid, 0);
    check("midrst_rvalid1", bus.req1_rvalid, 0);
    check("midrst_arvalid", bus.m_arvalid, 0);
    @(posedge tb_ACLK); #1;
    bus.m_rvalid = 1'b0;

    // Beat at index len without rlast also counts as a protocol error.
    request(0, 32'hB00, 4'd1, 1'b0);
    addr_phase(0);
    data_phase(0, 3, -1, 2);
    @(negedge tb_ACLK); #1;
    check("missing_rlast_proto", bus.proto_err, 1);
    check("missing_rlast_idle", bus.m_rready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mm_burst_arbiter.md
MM_BURST_ARBITER -- requirements
Module: mm_burst_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of requester and AXI address buses.
REQ-002 Parameter DATA_WIDTH, default 32, data width; beat size is fixed at 4 bytes.
REQ-003 ACLK  in  1  single clock; all logic on rising edge.
REQ-004 ARESETN  in  1  reset, synchronous and active-low.
REQ-005 reqN_valid  in  1  (N=0,1) requester N read-burst request.
REQ-006 reqN_addr  in  ADDR_WIDTH  start byte address, held while reqN_valid=1.
REQ-007 reqN_len  in  4  beats minus one (0..15), held while reqN_valid=1.
REQ-008 reqN_ready  out  1  one-cycle pulse when request N is accepted.
REQ-009 reqN_rdata  out  DATA_WIDTH  returned beat data.
REQ-010 reqN_rvalid  out  1  beat valid for requester N.
REQ-011 reqN_rlast  out  1  final beat for requester N.
REQ-012 reqN_err  out  1  one-cycle pulse: request rejected or burst completed with error.
REQ-013 m_arvalid, m_arready  out, in  1, 1  AXI4 AR handshake.
REQ-014 m_araddr  out  ADDR_WIDTH  AXI read address.
REQ-015 m_arlen  out  8  AXI burst length; {4'b0, len}.
REQ-016 m_arid  out  1  grantee index.
REQ-017 m_arsize, m_arburst  out  3, 2  constants 3'b010 and INCR 2'b01.
REQ-018 m_rvalid, m_rready  in, out  1, 1  AXI4 R handshake.
REQ-019 m_rdata, m_rresp, m_rlast  in  DATA_WIDTH, 2, 1  AXI read data, response, last.
REQ-020 proto_err  out  1  sticky flag: rlast position mismatch seen.

Function
REQ-021 FSM states IDLE, ADDR, DATA; only one burst outstanding at a time.
REQ-022 IDLE: if any reqN_valid, grant per round-robin, pulse reqN_ready for the grantee in that cycle, and latch addr, len and owner.
REQ-023 Round-robin: with both valid, grant the requester not granted last; with one valid, grant it; last_grant resets to 1, so req0 wins first contention.
REQ-024 Rejection: addr[1:0]!=0 or addr[11:0]+4*(len+1) > 4096 -> reqN_ready and reqN_err pulse together in the same cycle, no AXI traffic, stay in IDLE; last_grant is still updated.
REQ-025 Valid grant -> ADDR next cycle; m_arvalid=1 with latched fields stable until m_arready=1; arvalid does not depend on arready.
REQ-026 AR handshake -> DATA next cycle; m_arvalid drops.
REQ-027 DATA: m_rready=1; m_rready=0 in all other states.
REQ-028 In DATA, reqN_rvalid = m_rvalid and owner==N (combinational, zero latency); reqN_rdata = m_rdata for both requesters; reqN_rlast = m_rlast and owner==N.
REQ-029 5-bit beat counter cleared on AR handshake and incremented per R handshake.
REQ-030 m_rlast on a beat with count != len, or count == len without m_rlast -> proto_err set; on the m_rlast case the FSM returns to IDLE.
REQ-031 Beat with m_rresp!=2'b00 records a burst error; on the m_rlast handshake reqN_err pulses for the owner if any beat erred.
REQ-032 m_rlast handshake -> IDLE next cycle; arbitration for the next burst happens in that IDLE cycle, so the minimum burst-to-burst gap is 1 idle cycle.
REQ-033 A requester deasserting valid before ready is not an error; it is simply not granted.

Reset
REQ-034 ARESETN=0 at a clock edge -> IDLE, last_grant=1, counter=0, proto_err=0, burst error cleared; all outputs 0 except the constant m_arsize and m_arburst.
REQ-035 Reset mid-burst abandons the transaction; remaining R beats after reset are ignored (rready=0).

Verification
REQ-036 req0 addr 0x100, len 15; slave returns 16 OKAY beats -> m_araddr=0x100, m_arlen=15, 16 req0_rvalid, req0_rlast on beat 16, no err.
REQ-037 req0 and req1 valid from reset, both len 3 -> req0 served first, then req1; m_arid sequence 0,1; ready pulses 1 cycle each.
REQ-038 req1 addr 0xFF8, len 3 -> req1_ready and req1_err pulse in the same cycle; m_arvalid never asserts.
REQ-039 Slave holds arready=0 for 5 cycles -> m_arvalid and m_araddr stable all 5 cycles; beat 3 rresp=2'b10 -> err pulse at rlast.
REQ-040 len 7 with rlast on beat 5 -> proto_err=1 sticky, FSM in IDLE; then ARESETN low for 1 cycle mid-burst -> proto_err=0 and m_rready=0.
